// File: rtl/perf_counter_bank.sv
// Performance event counter bank: per-event counters plus a cycle counter, gated by a start/halt FSM.
// Optional build macro PERF_SATURATE_EN: counters saturate on overflow instead of wrapping.
//  state    | meaning
//  S_IDLE   | cleared or reset, waiting for start
//  S_COUNT  | accumulating events and cycles
//  S_FROZEN | halted, counters held for readout
module perf_counter_bank #(
    parameter int NUM_EVENTS = 16,
    parameter int CNT_WIDTH  = 32,
    localparam int IDX_W     = $clog2(NUM_EVENTS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  halt,
    input  logic [NUM_EVENTS-1:0] event_inc,
    input  logic                  rd_en,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic                  rd_valid,
    output logic [CNT_WIDTH-1:0]  rd_data,
    output logic                  counting,
    output logic                  frozen,
    output logic [NUM_EVENTS:0]   overflow
);

    localparam int NC = NUM_EVENTS + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
    localparam logic [IDX_W-1:0]     IDX_MAX = IDX_W'(NUM_EVENTS);

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_FROZEN} state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q [NC];
    logic [CNT_WIDTH-1:0]  cnt_d [NC];
    logic [NC-1:0]         ovf_q, ovf_d;
    logic [NC-1:0]         inc;
    logic                  cnt_en;
    logic                  rd_valid_q;
    logic [CNT_WIDTH-1:0]  rd_data_q, rd_word;
    logic                  counting_q, frozen_q;

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (start) state_d = halt ? S_FROZEN : S_COUNT;
                S_COUNT:  if (halt) state_d = S_FROZEN;
                S_FROZEN: if (start && !halt) state_d = S_COUNT;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // The cycle that transitions into FROZEN is still counted, including a same-cycle start&halt from IDLE.
    always_comb begin
        cnt_en = !clear && ((state_q == S_COUNT) || (state_q == S_IDLE && start && halt));
        inc    = {1'b1, event_inc};
        ovf_d  = ovf_q;
        for (int i = 0; i < NC; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_en && inc[i]) begin
                if (cnt_q[i] == '1) begin
                    ovf_d[i] = 1'b1;
`ifdef PERF_SATURATE_EN
                    cnt_d[i] = cnt_q[i];
`else
                    cnt_d[i] = '0;
`endif
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
            if (clear) cnt_d[i] = '0;
        end
        if (clear) ovf_d = '0;
    end

    always_comb begin
        rd_word = '0;
        if (rd_idx <= IDX_MAX) rd_word = cnt_q[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ovf_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            counting_q <= 1'b0;
            frozen_q   <= 1'b0;
            for (int i = 0; i < NC; i++) cnt_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_en;
            if (rd_en) rd_data_q <= rd_word;
            counting_q <= (state_d == S_COUNT);
            frozen_q   <= (state_d == S_FROZEN);
            for (int i = 0; i < NC; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign counting = counting_q;
    assign frozen   = frozen_q;
    assign overflow = ovf_q;

endmodule
